// File: rtl/bin_spectrogram_packer.sv
// bin_spectrogram_packer
// Packs the comparator's 1-bit per-bin detection stream into OW-bit words laid
// out column-major (NBIN bins per STFT column, NCOL columns per frame). Each
// finished word is emitted with its frame-relative address. End-of-column and
// end-of-frame pulses ride on the last word of a column or frame, and the
// column's ones count is presented alongside end-of-column.
module bin_spectrogram_packer #(
    parameter int OW   = 16,
    parameter int NBIN = 128,
    parameter int NCOL = 64,
    parameter int AW   = 9,
    parameter int CW   = 8
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iEN,
    input  logic          iDATA,
    input  logic          iCLR,
    output logic [OW-1:0] oDATA,
    output logic          oEN,
    output logic [AW-1:0] oADDR,
    output logic          oEOC,
    output logic          oEOF,
    output logic [CW-1:0] oCNT
);

    localparam int BW  = (OW > 1)   ? $clog2(OW)   : 1;
    localparam int KW  = (NBIN > 1) ? $clog2(NBIN) : 1;
    localparam int CLW = (NCOL > 1) ? $clog2(NCOL) : 1;

    localparam logic [BW-1:0]  BIT_LAST = BW'(OW - 1);
    localparam logic [KW-1:0]  BIN_LAST = KW'(NBIN - 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(NCOL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t stateReg, stateNext;

    logic [BW-1:0]  bitIdxReg,  bitIdxNext;
    logic [KW-1:0]  binIdxReg,  binIdxNext;
    logic [CLW-1:0] colIdxReg,  colIdxNext;
    logic [AW-1:0]  wordAddrReg, wordAddrNext;
    logic [CW-1:0]  onesCntReg, onesCntNext;
    logic [OW-1:0]  shiftReg,   shiftNext;

    logic [OW-1:0]  dataReg,  dataNext;
    logic           enReg,    enNext;
    logic [AW-1:0]  addrReg,  addrNext;
    logic           eocReg,   eocNext;
    logic           eofReg,   eofNext;
    logic [CW-1:0]  cntReg,   cntNext;

    // Counters as seen by the incoming bit: a clear in the same cycle makes
    // that bit the first one of a fresh frame.
    logic [BW-1:0]  bitBase;
    logic [KW-1:0]  binBase;
    logic [CLW-1:0] colBase;
    logic [AW-1:0]  wordBase;
    logic [CW-1:0]  onesBase;
    logic [OW-1:0]  shiftBase;
    logic [OW-1:0]  wordVal;
    logic [CW-1:0]  onesVal;

    // State, counters, shift register and output registers
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            stateReg    <= IDLE;
            bitIdxReg   <= '0;
            binIdxReg   <= '0;
            colIdxReg   <= '0;
            wordAddrReg <= '0;
            onesCntReg  <= '0;
            shiftReg    <= '0;
            dataReg     <= '0;
            enReg       <= 1'b0;
            addrReg     <= '0;
            eocReg      <= 1'b0;
            eofReg      <= 1'b0;
            cntReg      <= '0;
        end else begin
            stateReg    <= stateNext;
            bitIdxReg   <= bitIdxNext;
            binIdxReg   <= binIdxNext;
            colIdxReg   <= colIdxNext;
            wordAddrReg <= wordAddrNext;
            onesCntReg  <= onesCntNext;
            shiftReg    <= shiftNext;
            dataReg     <= dataNext;
            enReg       <= enNext;
            addrReg     <= addrNext;
            eocReg      <= eocNext;
            eofReg      <= eofNext;
            cntReg      <= cntNext;
        end
    end

    // Next-state: clear rebases the counters, then an accepted bit advances them
    always_comb begin
        stateNext    = stateReg;
        bitIdxNext   = bitIdxReg;
        binIdxNext   = binIdxReg;
        colIdxNext   = colIdxReg;
        wordAddrNext = wordAddrReg;
        onesCntNext  = onesCntReg;
        shiftNext    = shiftReg;
        dataNext     = dataReg;
        enNext       = 1'b0;
        addrNext     = addrReg;
        eocNext      = 1'b0;
        eofNext      = 1'b0;
        cntNext      = cntReg;

        bitBase   = iCLR ? '0 : bitIdxReg;
        binBase   = iCLR ? '0 : binIdxReg;
        colBase   = iCLR ? '0 : colIdxReg;
        wordBase  = iCLR ? '0 : wordAddrReg;
        onesBase  = iCLR ? '0 : onesCntReg;
        shiftBase = iCLR ? '0 : shiftReg;
        wordVal   = shiftBase | (OW'(iDATA) << bitBase);
        onesVal   = onesBase + CW'(iDATA);

        if (iCLR) begin
            stateNext    = IDLE;
            bitIdxNext   = '0;
            binIdxNext   = '0;
            colIdxNext   = '0;
            wordAddrNext = '0;
            onesCntNext  = '0;
            shiftNext    = '0;
        end

        if (iEN) begin
            stateNext = FILL;

            if (bitBase == BIT_LAST) begin
                dataNext     = wordVal;
                addrNext     = wordBase;
                enNext       = 1'b1;
                shiftNext    = '0;
                bitIdxNext   = '0;
                wordAddrNext = wordBase + AW'(1);
            end else begin
                shiftNext  = wordVal;
                bitIdxNext = bitBase + BW'(1);
            end

            // NBIN is a multiple of OW, so a column end is always a word end
            // and the frame-end address wrap below overrides the increment.
            if (binBase == BIN_LAST) begin
                eocNext     = 1'b1;
                cntNext     = onesVal;
                onesCntNext = '0;
                binIdxNext  = '0;
                if (colBase == COL_LAST) begin
                    eofNext      = 1'b1;
                    colIdxNext   = '0;
                    wordAddrNext = '0;
                end else begin
                    colIdxNext = colBase + CLW'(1);
                end
            end else begin
                binIdxNext  = binBase + KW'(1);
                onesCntNext = onesVal;
            end
        end
    end

    assign oDATA = dataReg;
    assign oEN   = enReg;
    assign oADDR = addrReg;
    assign oEOC  = eocReg;
    assign oEOF  = eofReg;
    assign oCNT  = cntReg;

endmodule
